dff_response_checker: RTL and testbench

- Synthesizable, clocked response checker that sits on the output side of the team's D flip-flop block.
- Watches the flip-flop's inputs (d, reset, preset) and its output q, keeps a reference model of the expected q, and compares the observed q against it every cycle.
- Reports check/error counts, a sticky fail flag and first-mismatch capture, so flip-flop regressions can be self-checking in hardware and in simulation.

---
 rtl/dff_response_checker_if.sv | 29 ++
 rtl/dff_response_checker.sv | 112 +++++++++++
 tb/tb_dff_response_checker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dff_response_checker_if.sv
// dff_response_checker_if: control, monitored flip-flop signals and status of the response checker.
interface dff_response_checker_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] mon_d;
    logic             mon_rst;
    logic             mon_pre;
    logic [WIDTH-1:0] mon_q;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] check_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0] first_exp;
    logic [WIDTH-1:0] first_got;

    modport master (
        output enable, clear, mon_d, mon_rst, mon_pre, mon_q,
        input  busy, pass, fail, check_cnt, err_cnt, first_exp, first_got
    );

    modport slave (
        input  enable, clear, mon_d, mon_rst, mon_pre, mon_q,
        output busy, pass, fail, check_cnt, err_cnt, first_exp, first_got
    );
endinterface

// File: rtl/dff_response_checker.sv
// dff_response_checker: compares a D flip-flop's q against a one-cycle-late reference model.
// Define CHECKER_PRESET_EN to make the model honour mon_pre; otherwise mon_pre is ignored.
module dff_response_checker #(
    parameter int WIDTH     = 1,
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    dff_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WARMUP, CHECK, FAULT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, model;
    logic [WIDTH-1:0] first_exp_q, first_exp_d, first_got_q, first_got_d;
    logic [CNT_W-1:0] check_cnt_q, check_cnt_d, err_cnt_q, err_cnt_d;
    logic             exp_valid_q, exp_valid_d, fail_q, fail_d;
    logic             busy_q, busy_d, pass_q, pass_d, mismatch;

`ifdef CHECKER_PRESET_EN
    assign model = bus.mon_rst ? '0 : bus.mon_pre ? '1 : bus.mon_d;
`else
    logic unused_pre;
    assign unused_pre = bus.mon_pre;
    assign model = bus.mon_rst ? '0 : bus.mon_d;
`endif

    // X/Z on mon_q must count as a mismatch, hence the case inequality
    assign mismatch = exp_valid_q && (bus.mon_q !== exp_q);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        exp_valid_d = exp_valid_q;
        check_cnt_d = check_cnt_q;
        err_cnt_d   = err_cnt_q;
        fail_d      = fail_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;
        if (bus.clear) begin
            state_d     = IDLE;
            exp_valid_d = 1'b0;
            check_cnt_d = '0;
            err_cnt_d   = '0;
            fail_d      = 1'b0;
            first_exp_d = '0;
            first_got_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = bus.enable ? WARMUP : IDLE;
                WARMUP, CHECK: begin
                    if (!bus.enable) begin
                        state_d     = IDLE;
                        exp_valid_d = 1'b0;
                    end else begin
                        state_d     = CHECK;
                        exp_d       = model;
                        exp_valid_d = 1'b1;
                        if (exp_valid_q) begin
                            check_cnt_d = &check_cnt_q ? check_cnt_q : check_cnt_q + CNT_W'(1);
                            if (mismatch) begin
                                err_cnt_d   = &err_cnt_q ? err_cnt_q : err_cnt_q + CNT_W'(1);
                                fail_d      = 1'b1;
                                first_exp_d = fail_q ? first_exp_q : exp_q;
                                first_got_d = fail_q ? first_got_q : bus.mon_q;
                                state_d     = (err_cnt_d == CNT_W'(ERR_LIMIT)) ? FAULT : CHECK;
                            end
                        end
                    end
                end
                default: state_d = FAULT;
            endcase
        end
        busy_d = (state_d == WARMUP) || (state_d == CHECK);
        pass_d = (state_d == CHECK) && (err_cnt_d == '0) && (check_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            exp_valid_q <= 1'b0;
            check_cnt_q <= '0;
            err_cnt_q   <= '0;
            fail_q      <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            exp_valid_q <= exp_valid_d;
            check_cnt_q <= check_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fail_q      <= fail_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.check_cnt = check_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.first_exp = first_exp_q;
    assign bus.first_got = first_got_q;
endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker: directed and random checks of dff_response_checker against a behavioural model.
module tb_dff_response_checker;
    localparam int W   = 1;
    localparam int CW  = 16;
    localparam int LIM = 4;
`ifdef CHECKER_PRESET_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    dff_response_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    dff_response_checker #(.WIDTH(W), .CNT_W(CW), .ERR_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural model: running/warming/faulted flags, counts and the last expected value
    bit   m_on, m_warm, m_fault, m_valid, m_fail;
    int   m_checks, m_errs;
    logic m_exp, m_fe, m_fg;
    logic ff_q = 1'b0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        m_on = 0; m_warm = 0; m_fault = 0; m_valid = 0; m_fail = 0;
        m_checks = 0; m_errs = 0; m_fe = 0; m_fg = 0;
    endtask

    task automatic model_edge();
        logic nxt;
        nxt = bus.mon_rst ? 1'b0 : (PRE && bus.mon_pre) ? 1'b1 : bus.mon_d;
        if (!reset) begin
            model_zero();
            m_exp = 0;
        end else if (bus.clear) begin
            model_zero();
        end else if (m_fault) begin
        end else if (!m_on) begin
            if (bus.enable) begin m_on = 1; m_warm = 1; end
        end else if (!bus.enable) begin
            m_on = 0; m_warm = 0; m_valid = 0;
        end else begin
            if (m_valid) begin
                if (m_checks < 65535) m_checks++;
                if (bus.mon_q !== m_exp) begin
                    if (m_errs < 65535) m_errs++;
                    if (!m_fail) begin m_fail = 1; m_fe = m_exp; m_fg = bus.mon_q; end
                    if (m_errs == LIM) begin m_fault = 1; m_on = 0; end
                end
            end
            m_exp = nxt; m_valid = 1; m_warm = 0;
        end
        ff_q = nxt;
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".busy"}, 32'(bus.busy), 32'(m_on));
        cmp({tag, ".pass"}, 32'(bus.pass), 32'(m_on && !m_warm && m_errs == 0 && m_checks != 0));
        cmp({tag, ".fail"}, 32'(bus.fail), 32'(m_fail));
        cmp({tag, ".check_cnt"}, 32'(bus.check_cnt), 32'(m_checks));
        cmp({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_errs));
        cmp({tag, ".first_exp"}, 32'(bus.first_exp), 32'(m_fe));
        cmp({tag, ".first_got"}, 32'(bus.first_got), 32'(m_fg));
    endtask

    // qm: 0 = correct flip-flop q, 1 = inverted q, 2 = q forced to 0
    task automatic step(input string tag, input bit en, input bit clr, input logic d,
                        input bit r, input bit p, input int qm);
        bus.enable = en; bus.clear = clr; bus.mon_d = d; bus.mon_rst = r; bus.mon_pre = p;
        bus.mon_q = (qm == 0) ? ff_q : (qm == 1) ? ~ff_q : 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_zero();
        m_exp = 0;
        reset = 0;
        step("rst0", 0, 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0, 0);
        cmp("rst_busy", 32'(bus.busy), 0);
        cmp("rst_checks", 32'(bus.check_cnt), 0);
        reset = 1;
        step("idle", 0, 0, 0, 0, 0, 0);
        cmp("idle_busy", 32'(bus.busy), 0);
        step("warm_in", 1, 0, 1, 0, 0, 0);
        cmp("warm_busy", 32'(bus.busy), 1);
        step("warm_abort", 0, 0, 1, 0, 0, 0);
        cmp("abort_busy", 32'(bus.busy), 0);

        step("tp2_en", 1, 0, 0, 0, 0, 0);
        step("tp2_rst", 1, 0, 0, 1, 0, 0);
        step("tp2_pre", 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("tp2_d", 1, 0, logic'(i % 2), 0, 0, 0);
        cmp("tp2_checks", 32'(bus.check_cnt), 5);
        cmp("tp2_errs", 32'(bus.err_cnt), 0);
        cmp("tp2_pass", 32'(bus.pass), 1);
        cmp("tp2_busy", 32'(bus.busy), 1);

        step("tp3_one", 1, 0, 1, 0, 0, 0);
        step("tp3_bad", 1, 0, 0, 0, 0, 2);
        cmp("tp3_fail", 32'(bus.fail), 1);
        cmp("tp3_errs", 32'(bus.err_cnt), 1);
        cmp("tp3_fexp", 32'(bus.first_exp), 1);
        cmp("tp3_fgot", 32'(bus.first_got), 0);
        cmp("tp3_busy", 32'(bus.busy), 1);

        step("tp4_clr", 1, 1, 0, 0, 0, 0);
        cmp("tp4_clr_busy", 32'(bus.busy), 0);
        step("tp4_en", 1, 0, 1, 0, 0, 0);
        step("tp4_warm", 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("tp4_inj", 1, 0, logic'(i % 2), 0, 0, 1);
        cmp("tp4_checks", 32'(bus.check_cnt), 4);
        cmp("tp4_errs", 32'(bus.err_cnt), 4);
        cmp("tp4_busy", 32'(bus.busy), 0);
        cmp("tp4_pass", 32'(bus.pass), 0);
        for (int i = 0; i < 2; i++) step("tp4_frozen", 1, 0, 1, 0, 0, 1);
        cmp("tp4_frz_checks", 32'(bus.check_cnt), 4);
        cmp("tp4_frz_errs", 32'(bus.err_cnt), 4);
        step("tp4_clear", 0, 1, 0, 0, 0, 0);
        cmp("tp4_clr_checks", 32'(bus.check_cnt), 0);
        cmp("tp4_clr_errs", 32'(bus.err_cnt), 0);
        cmp("tp4_clr_fail", 32'(bus.fail), 0);

        step("tp5_en", 1, 0, 1, 0, 0, 0);
        step("tp5_load", 1, 0, 1, 1, 1, 0);
        step("tp5_q0", 1, 0, 1, 1, 1, 0);
        cmp("tp5_rp_ok", 32'(bus.err_cnt), 0);
        step("tp5_q1", 1, 0, 1, 1, 1, 1);
        cmp("tp5_rp_bad", 32'(bus.err_cnt), 1);
        step("tp5_pre", 1, 0, 0, 0, 1, 0);
        step("tp5_preq0", 1, 0, 0, 0, 0, 2);
        cmp("tp5_pre_only", 32'(bus.err_cnt), PRE ? 2 : 1);

        step("tp6_clr", 0, 1, 0, 0, 0, 0);
        step("tp6_en", 1, 0, 0, 0, 0, 0);
        step("tp6_warm", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("tp6_inj", 1, 0, 1, 0, 0, 1);
        cmp("tp6_errs2", 32'(bus.err_cnt), 2);
        reset = 0;
        step("tp6_rst", 1, 0, 0, 0, 0, 0);
        cmp("tp6_rst_errs", 32'(bus.err_cnt), 0);
        cmp("tp6_rst_fail", 32'(bus.fail), 0);
        cmp("tp6_rst_busy", 32'(bus.busy), 0);
        reset = 1;
        step("tp6_re_en", 1, 0, 1, 0, 0, 0);
        cmp("tp6_e1_checks", 32'(bus.check_cnt), 0);
        step("tp6_re_warm", 1, 0, 1, 0, 0, 0);
        cmp("tp6_e2_checks", 32'(bus.check_cnt), 0);
        step("tp6_re_cmp", 1, 0, 0, 0, 0, 0);
        cmp("tp6_e3_checks", 32'(bus.check_cnt), 1);

        step("rnd_clr", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 79) != 0);
            step("rnd", 1, $urandom_range(0, 39) == 0, logic'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 9) == 0) ? 1 : 0);
        end
        reset = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
